// File: rtl/rpll_pkg.sv
// Shared limits and helpers for the rpll cycle model: divider decoding and
// PFD/VCO legality of a divider configuration.
package rpll_pkg;

    localparam int PFD_MIN_KHZ = 3000;
    localparam int PFD_MAX_KHZ = 400000;
    localparam int VCO_MIN_KHZ = 400000;
    localparam int VCO_MAX_KHZ = 1200000;

    // Width of the clock-generator counters; covers SDIV*ODIV up to 128*128.
    localparam int CG_W = 16;

    // Dynamic divider ports encode the divider as 64 - code (range 1..64).
    function automatic logic [6:0] code_to_div(input logic [5:0] code);
        return 7'd64 - {1'b0, code};
    endfunction

    function automatic logic odiv_legal(input int odiv);
        case (odiv)
            2, 4, 8, 16, 32, 48, 64, 80, 96, 112, 128: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic cfg_legal(input int fclk_khz, input int n,
                                       input int m, input int odiv);
        int pfd;
        int vco;
        pfd = fclk_khz / n;
        vco = fclk_khz * m * odiv / n;
        return odiv_legal(odiv)
            && (pfd >= PFD_MIN_KHZ) && (pfd <= PFD_MAX_KHZ)
            && (vco >= VCO_MIN_KHZ) && (vco <= VCO_MAX_KHZ);
    endfunction

endpackage

// File: rtl/rpll_clkgen.sv
// Divided clock generator: a counter over 'period' CLKIN cycles whose
// registered output is high for 'high' cycles starting 'phase' cycles in.
module rpll_clkgen
    import rpll_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic [CG_W-1:0] period,
    input  logic [CG_W-1:0] high,
    input  logic [CG_W-1:0] phase,
    output logic            out,
    output logic            last
);

    localparam logic [CG_W-1:0] ONE = CG_W'(1);

    logic [CG_W-1:0] cnt;
    logic [CG_W-1:0] pos;

    // pos is the position inside the period measured from the shifted rising edge.
    always_comb begin
        last = (cnt == period - ONE);
        pos  = (cnt >= phase) ? (cnt - phase) : (cnt + period - phase);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
            out <= 1'b0;
        end else begin
            out <= (pos < high);
            cnt <= last ? '0 : (cnt + ONE);
        end
    end

endmodule

// File: rtl/rpll.sv
// Cycle model of a PLL: CLKIN is the VCO-rate timebase, every output is a
// register, and LOCK follows a fixed cycle count from the start of each run.
module rpll #(
    parameter string FCLKIN        = "100.0",
    parameter int    FCLKIN_KHZ    = 100000,
    parameter int    IDIV_SEL      = 0,
    parameter int    FBDIV_SEL     = 0,
    parameter int    ODIV_SEL      = 8,
    parameter int    DYN_SDIV_SEL  = 2,
    parameter string DYN_IDIV_SEL  = "false",
    parameter string DYN_FBDIV_SEL = "false",
    parameter string DYN_ODIV_SEL  = "false",
    parameter int    LOCK_CYCLES   = 256
) (
    input  logic       CLKIN,
    input  logic       RESET,
    input  logic       RESET_P,
    input  logic       CLKFB,
    input  logic [5:0] IDSEL,
    input  logic [5:0] FBDSEL,
    input  logic [5:0] ODSEL,
    input  logic [3:0] PSDA,
    input  logic [3:0] DUTYDA,
    input  logic [3:0] FDLY,
    output logic       CLKOUT,
    output logic       CLKOUTP,
    output logic       CLKOUTD,
    output logic       CLKOUTD3,
    output logic       LOCK
);

    import rpll_pkg::*;

    localparam bit DYN_I = (DYN_IDIV_SEL == "true");
    localparam bit DYN_F = (DYN_FBDIV_SEL == "true");
    localparam bit DYN_O = (DYN_ODIV_SEL == "true");
    localparam bit ODIV_SEL_OK = odiv_legal(ODIV_SEL);
    localparam logic [CG_W-1:0] SDIV = CG_W'(DYN_SDIV_SEL);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);
    localparam string unused_fclkin = FCLKIN;

    logic [6:0]      n_eff, m_eff, n_q, m_q;
    logic [7:0]      odiv_eff, odiv_q;
    logic            legal, changed, clr;
    logic [3:0]      psda_q, duty_q;
    logic [CG_W-1:0] odiv_w, main_high, p_phase, p_high, p_duty;
    logic [CG_W-1:0] d_period, d3_period;
    logic            main_last;
    logic [2:0]      unused_last;
    logic            unused_inputs;
    logic [31:0]     lock_cnt;
    logic            lock_q;

    assign unused_inputs = ^{CLKFB, FDLY, IDSEL, FBDSEL, ODSEL};

    // A run is held cleared by reset, power-down, an illegal configuration,
    // or for one cycle whenever an effective divider changes.
    always_comb begin
        n_eff    = DYN_I ? code_to_div(IDSEL)  : 7'(IDIV_SEL + 1);
        m_eff    = DYN_F ? code_to_div(FBDSEL) : 7'(FBDIV_SEL + 1);
        odiv_eff = DYN_O ? {1'b0, code_to_div(ODSEL)} : 8'(ODIV_SEL);
        legal    = cfg_legal(FCLKIN_KHZ, int'(n_eff), int'(m_eff), int'(odiv_eff))
                   && (DYN_O || ODIV_SEL_OK);
        changed  = ({n_eff, m_eff, odiv_eff} != {n_q, m_q, odiv_q});
        clr      = RESET | RESET_P | changed | ~legal;
    end

    always_comb begin
        odiv_w    = {8'd0, odiv_eff};
        main_high = odiv_w >> 1;
        p_phase   = ({12'd0, psda_q} * odiv_w) >> 4;
        p_duty    = ({12'd0, duty_q} * odiv_w) >> 4;
        p_high    = (p_duty == '0) ? main_high : p_duty;
        d_period  = SDIV * odiv_w;
        d3_period = odiv_w * CG_W'(3);
    end

    // Phase/duty codes only move on a CLKOUT period boundary so CLKOUTP never
    // sees a half-updated period.
    always_ff @(posedge CLKIN) begin
        n_q    <= n_eff;
        m_q    <= m_eff;
        odiv_q <= odiv_eff;
        if (clr || main_last) begin
            psda_q <= PSDA;
            duty_q <= DUTYDA;
        end
        if (clr) begin
            lock_cnt <= '0;
            lock_q   <= 1'b0;
        end else if (!lock_q) begin
            lock_cnt <= lock_cnt + 32'd1;
            if (lock_cnt == LOCK_LAST) begin
                lock_q <= 1'b1;
            end
        end
    end

    assign LOCK = lock_q;

    rpll_clkgen u_clkout (
        .clk    (CLKIN),
        .clr    (clr),
        .period (odiv_w),
        .high   (main_high),
        .phase  ('0),
        .out    (CLKOUT),
        .last   (main_last)
    );

    rpll_clkgen u_clkoutp (
        .clk    (CLKIN),
        .clr    (clr),
        .period (odiv_w),
        .high   (p_high),
        .phase  (p_phase),
        .out    (CLKOUTP),
        .last   (unused_last[0])
    );

    rpll_clkgen u_clkoutd (
        .clk    (CLKIN),
        .clr    (clr),
        .period (d_period),
        .high   (d_period >> 1),
        .phase  ('0),
        .out    (CLKOUTD),
        .last   (unused_last[1])
    );

    rpll_clkgen u_clkoutd3 (
        .clk    (CLKIN),
        .clr    (clr),
        .period (d3_period),
        .high   (d3_period >> 1),
        .phase  ('0),
        .out    (CLKOUTD3),
        .last   (unused_last[2])
    );

endmodule

// File: tb/tb_rpll.sv
// Bench for rpll: three instances (legal static, illegal static, dynamic ODIV)
// checked every cycle against an expected-word queue from a waveform model.
module tb_rpll;

    localparam int LOCK_N = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rstp_a, zero1;
    logic [3:0] psda, dutyda, zero4;
    logic [5:0] idsel_a, fbdsel_a, odsel_a, odsel_c, zero6;

    logic a_clk, a_clkp, a_clkd, a_clkd3, a_lock;
    logic b_clk, b_clkp, b_clkd, b_clkd3, b_lock;
    logic c_clk, c_clkp, c_clkd, c_clkd3, c_lock;

    logic [14:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Model state per instance: run index, sampled phase and duty codes.
    int k[3];
    int cp[3];
    int cd[3];
    int prev_code_c;

    rpll #(.FCLKIN("27.0"), .FCLKIN_KHZ(27000), .IDIV_SEL(2), .FBDIV_SEL(7),
           .ODIV_SEL(8), .DYN_SDIV_SEL(2), .LOCK_CYCLES(LOCK_N)) u_a (
        .CLKIN(clk), .RESET(rst), .RESET_P(rstp_a), .CLKFB(zero1),
        .IDSEL(idsel_a), .FBDSEL(fbdsel_a), .ODSEL(odsel_a),
        .PSDA(psda), .DUTYDA(dutyda), .FDLY(zero4),
        .CLKOUT(a_clk), .CLKOUTP(a_clkp), .CLKOUTD(a_clkd), .CLKOUTD3(a_clkd3), .LOCK(a_lock)
    );

    rpll #(.FCLKIN("27.0"), .FCLKIN_KHZ(27000), .IDIV_SEL(2), .FBDIV_SEL(7),
           .ODIV_SEL(2), .DYN_SDIV_SEL(2), .LOCK_CYCLES(LOCK_N)) u_b (
        .CLKIN(clk), .RESET(rst), .RESET_P(zero1), .CLKFB(zero1),
        .IDSEL(zero6), .FBDSEL(zero6), .ODSEL(zero6),
        .PSDA(psda), .DUTYDA(dutyda), .FDLY(zero4),
        .CLKOUT(b_clk), .CLKOUTP(b_clkp), .CLKOUTD(b_clkd), .CLKOUTD3(b_clkd3), .LOCK(b_lock)
    );

    rpll #(.FCLKIN("27.0"), .FCLKIN_KHZ(27000), .IDIV_SEL(2), .FBDIV_SEL(7),
           .ODIV_SEL(8), .DYN_SDIV_SEL(2), .DYN_ODIV_SEL("true"), .LOCK_CYCLES(LOCK_N)) u_c (
        .CLKIN(clk), .RESET(rst), .RESET_P(zero1), .CLKFB(zero1),
        .IDSEL(zero6), .FBDSEL(zero6), .ODSEL(odsel_c),
        .PSDA(psda), .DUTYDA(dutyda), .FDLY(zero4),
        .CLKOUT(c_clk), .CLKOUTP(c_clkp), .CLKOUTD(c_clkd), .CLKOUTD3(c_clkd3), .LOCK(c_lock)
    );

    function automatic bit wave(int kk, int per, int hi, int ph);
        int pos;
        pos = (kk - ph) % per;
        if (pos < 0) pos += per;
        return pos < hi;
    endfunction

    function automatic int odiv_of(int i);
        if (i == 0) return 8;
        if (i == 1) return 2;
        return 64 - int'(odsel_c);
    endfunction

    // Reference 27 MHz, N=3, M=8 for every instance.
    function automatic bit legal_of(int i);
        int o;
        int vco;
        bit in_set;
        o = odiv_of(i);
        in_set = (o == 2) || (o == 4) || (o == 8) || (o == 16) || (o == 32) || (o == 48) ||
                 (o == 64) || (o == 80) || (o == 96) || (o == 112) || (o == 128);
        vco = 27000 * 8 * o / 3;
        return in_set && (vco >= 400000) && (vco <= 1200000);
    endfunction

    function automatic bit clr_of(int i);
        return rst || (i == 0 && rstp_a) || !legal_of(i) ||
               (i == 2 && int'(odsel_c) != prev_code_c);
    endfunction

    // {CLKOUT, CLKOUTP, CLKOUTD, CLKOUTD3, LOCK}; index 0 is the first edge of a run.
    function automatic logic [4:0] model_word(int i);
        int o;
        int hp;
        o  = odiv_of(i);
        hp = cd[i] * o / 16;
        if (hp == 0) hp = o / 2;
        return {wave(k[i], o, o / 2, 0), wave(k[i], o, hp, cp[i] * o / 16),
                wave(k[i], 2 * o, o, 0), wave(k[i], 3 * o, 3 * o / 2, 0),
                (k[i] >= LOCK_N - 1)};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit clr[3];
        logic [4:0] e[3];
        logic [14:0] w;
        for (int i = 0; i < 3; i++) begin
            clr[i] = clr_of(i);
            e[i] = clr[i] ? 5'b0 : model_word(i);
        end
        exp_q.push_back({e[0], e[1], e[2]});
        @(posedge clk);
        #1;
        w = exp_q.pop_front();
        check("inst_a", {a_clk, a_clkp, a_clkd, a_clkd3, a_lock}, w[14:10]);
        check("inst_b", {b_clk, b_clkp, b_clkd, b_clkd3, b_lock}, w[9:5]);
        check("inst_c", {c_clk, c_clkp, c_clkd, c_clkd3, c_lock}, w[4:0]);
        for (int i = 0; i < 3; i++) begin
            if (clr[i]) begin
                k[i]  = 0;
                cp[i] = int'(psda);
                cd[i] = int'(dutyda);
            end else begin
                if (k[i] % odiv_of(i) == odiv_of(i) - 1) begin
                    cp[i] = int'(psda);
                    cd[i] = int'(dutyda);
                end
                k[i]++;
            end
        end
        prev_code_c = int'(odsel_c);
    endtask

    initial begin
        rst = 1'b1; rstp_a = 1'b0; zero1 = 1'b0; zero4 = '0; zero6 = '0;
        psda = '0; dutyda = '0;
        idsel_a = '0; fbdsel_a = '0; odsel_a = '0;
        odsel_c = 6'd56;
        prev_code_c = 56;
        for (int i = 0; i < 3; i++) begin
            k[i] = 0; cp[i] = 0; cd[i] = 0;
        end

        // Reset state.
        repeat (3) step();

        // Static run with lock; A's dynamic ports wiggle and must be ignored.
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            idsel_a  = 6'($urandom_range(0, 63));
            fbdsel_a = 6'($urandom_range(0, 63));
            odsel_a  = 6'($urandom_range(0, 63));
            step();
        end

        // Quarter-period phase shift and quarter duty.
        psda = 4'd4; dutyda = 4'd4;
        repeat (40) step();

        // Codes changed at arbitrary points take effect at period boundaries.
        for (int j = 0; j < 4; j++) begin
            psda   = 4'($urandom_range(0, 15));
            dutyda = 4'($urandom_range(0, 15));
            repeat ($urandom_range(5, 20)) step();
        end
        psda = '0; dutyda = '0;
        repeat (16) step();

        // Power-down pulse mid-period on the locked instance, then relock.
        for (int g = 0; g < 16 && (k[0] % 8) != 3; g++) step();
        rstp_a = 1'b1;
        step();
        rstp_a = 1'b0;
        repeat (300) step();

        // Dynamic ODIV 8 -> 16, then an illegal code (ODIV 6), then back to 8.
        odsel_c = 6'd48;
        repeat (60) step();
        odsel_c = 6'd58;
        repeat (10) step();
        odsel_c = 6'd56;
        repeat (30) step();

        // Global reset mid-run.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rpll.md
RPLL -- requirements
Module: rpll

Interface
REQ-001 Parameters: FCLKIN, "100.0", reference frequency in MHz as a string; informational only.
REQ-002 Parameters: FCLKIN_KHZ, 100000, reference frequency in kHz; used for legality checks.
REQ-003 Parameters: IDIV_SEL (0..63), 0, input divider N = IDIV_SEL+1.
REQ-004 Parameters: FBDIV_SEL (0..63), 0, feedback multiplier M = FBDIV_SEL+1.
REQ-005 Parameters: ODIV_SEL, 8, output divider; legal values 2,4,8,16,32,48,64,80,96,112,128.
REQ-006 Parameters: DYN_SDIV_SEL, 2, CLKOUTD divider; even, 2..128.
REQ-007 Parameters: DYN_IDIV_SEL / DYN_FBDIV_SEL / DYN_ODIV_SEL, "false", "true" selects the IDSEL/FBDSEL/ODSEL ports.
REQ-008 Parameters: LOCK_CYCLES, 256, timebase cycles from start of run to LOCK.
REQ-009 Ports: CLKIN in 1, model timebase clock at conceptual VCO rate; the block's only clock.
REQ-010 Ports: RESET in 1, synchronous, active-high.
REQ-011 Ports: RESET_P in 1, synchronous power-down.
REQ-012 Ports: CLKFB in 1, ignored (internal feedback).
REQ-013 Ports: IDSEL, FBDSEL and ODSEL in 6 each, dynamic divider codes; effective value = 64 − code.
REQ-014 Ports: PSDA in 4, CLKOUTP phase in 1/16 period; DUTYDA in 4, CLKOUTP high time in 1/16 period (0 = 50%).
REQ-015 Ports: FDLY in 4, ignored.
REQ-016 Ports: CLKOUT, CLKOUTP, CLKOUTD, CLKOUTD3 and LOCK out 1 each; main clock, phase/duty-adjusted clock, CLKOUT/SDIV, CLKOUT/3, lock flag.

Function
REQ-017 The block SHALL be a cycle model: every output SHALL be a register clocked by CLKIN with no combinational path from any input.
REQ-018 CLKOUT SHALL have period ODIV cycles, high for the first ODIV/2 cycles of each period.
REQ-019 CLKOUTP SHALL share CLKOUT's period; its rising edge SHALL lag CLKOUT's by floor(PSDA×ODIV/16) cycles; high time SHALL be floor(DUTYDA×ODIV/16) cycles, or ODIV/2 when DUTYDA=0 or the product is 0.
REQ-020 PSDA/DUTYDA SHALL be sampled only at the CLKOUT period boundary.
REQ-021 CLKOUTD SHALL have period SDIV×ODIV cycles with 50% duty, rising edges coincident with CLKOUT rising edges.
REQ-022 CLKOUTD3 SHALL have period 3×ODIV cycles, high for the first 1.5×ODIV cycles, rising coincident with CLKOUT.
REQ-023 Legality SHALL be checked on effective N, M, ODIV: PFD = FCLKIN_KHZ/N in 3000..400000 kHz, and VCO = FCLKIN_KHZ×M×ODIV/N in 400000..1200000 kHz, using 32-bit integer arithmetic.
REQ-024 Illegal configuration SHALL hold all outputs and LOCK at 0.
REQ-025 LOCK SHALL assert exactly LOCK_CYCLES cycles after run start and SHALL stay high until reset, power-down, or a divider change.
REQ-026 Outputs SHALL toggle from run start, before LOCK.
REQ-027 In dynamic mode, any change of an effective divider value SHALL drop LOCK and restart all counters on the next cycle (new run start).
REQ-028 Static mode SHALL ignore the IDSEL/FBDSEL/ODSEL ports.
REQ-029 An illegal dynamic ODIV code SHALL be treated as an illegal configuration.

Reset
REQ-030 While RESET or RESET_P is high, all counters SHALL clear and all outputs and LOCK SHALL be 0; the first cycle after release is run start.
REQ-031 Asserting RESET or RESET_P mid-period SHALL force the outputs low on the next edge.
REQ-032 RESET and RESET_P together SHALL behave as one reset.

Structure
REQ-033 Package rpll_pkg SHALL hold the PFD/VCO limit constants, the legal-ODIV check function and the code-to-divider function.
REQ-034 Sub-module rpll_clkgen (period, high time, phase offset) SHALL be instantiated once each for CLKOUT, CLKOUTP, CLKOUTD and CLKOUTD3.

Verification
REQ-035 FCLKIN_KHZ=27000, IDIV_SEL=2, FBDIV_SEL=7, ODIV_SEL=8, PSDA=DUTYDA=0 -> CLKOUT period 8 (4 high); CLKOUTP identical; LOCK rises 256 cycles after RESET release.
REQ-036 Same configuration -> CLKOUTD period 16; CLKOUTD3 period 24, high 12, rising with CLKOUT.
REQ-037 PSDA=4, DUTYDA=4, ODIV=8 -> CLKOUTP lags 2 cycles, high 2 of 8.
REQ-038 ODIV_SEL=2 at 27 MHz, N=3, M=8 (VCO 144 MHz) -> all outputs 0, LOCK never rises.
REQ-039 RESET_P pulsed mid-period after lock -> outputs and LOCK 0 next edge; clean restart; LOCK again after 256 cycles.
REQ-040 DYN_ODIV_SEL="true", ODSEL changes from 56 (ODIV 8) to 48 (ODIV 16) -> LOCK drops next cycle; CLKOUT period 16 thereafter.
